// File: rtl/multi4.sv
// multi4: 4x4 sequential shift-add multiplier, IDLE -> CALC (4 edges) -> DONE.
// Define MULTI4_SIGNED_EN to treat A, B and P as two's complement.
module multi4 (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] A,
   input  logic [3:0] B,
   output logic [7:0] P,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t     state;
   logic [3:0] a_q;
   logic [3:0] b_q;
   logic [7:0] acc;
   logic [1:0] cnt;

   logic [7:0] a_ext;
   logic [7:0] pp;
   logic [7:0] acc_next;

   // Partial product for the current iteration and the accumulator it produces.
   // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
`ifdef MULTI4_SIGNED_EN
      a_ext = {{4{a_q[3]}}, a_q};
`else
      a_ext = {4'b0000, a_q};
`endif
      pp       = a_ext << cnt;
      acc_next = acc;
      if (b_q[cnt]) begin
`ifdef MULTI4_SIGNED_EN
         // B[3] carries weight -8 in two's complement, so its partial product is subtracted.
         if (cnt == 2'd3) acc_next = acc - pp;
         else             acc_next = acc + pp;
`else
         acc_next = acc + pp;
`endif
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         a_q   <= 4'h0;
         b_q   <= 4'h0;
         acc   <= 8'h00;
         cnt   <= 2'd0;
         P     <= 8'h00;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state <= S_CALC;
                  a_q   <= A;
                  b_q   <= B;
                  acc   <= 8'h00;
                  cnt   <= 2'd0;
                  busy  <= 1'b1;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_CALC: begin
               acc <= acc_next;
               cnt <= cnt + 2'd1;
               // Last iteration: publish the finished accumulator directly into P.
               if (cnt == 2'd3) begin
                  P     <= acc_next;
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multi4.sv
// Scoreboard bench for multi4: driver pushes expected products, a monitor pops on done.
// Build with MULTI4_SIGNED_EN defined to check the two's-complement variant.
module tb_multi4;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] A;
   logic [3:0] B;
   logic [7:0] P;
   logic       busy;
   logic       done;

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  last_p;

   multi4 dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .A    (A),
      .B    (B),
      .P    (P),
      .busy (busy),
      .done (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer product of the operands as numbers.
   function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b);
      int x;
      int y;
      x = int'(a);
      y = int'(b);
`ifdef MULTI4_SIGNED_EN
      if (x > 7) x = x - 16;
      if (y > 7) y = y - 16;
`endif
      return 8'(x * y);
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
         end else begin
            check("product", 32'(P), 32'(exp_q.pop_front()));
         end
      end
   end

   // Accept edge: operands presented at a negedge, taken on the following posedge.
   task automatic launch(input logic [3:0] a, input logic [3:0] b, input bit expect_result);
      @(negedge clk);
      start = 1'b1;
      A     = a;
      B     = b;
      if (expect_result) begin
         exp_q.push_back(model(a, b));
         last_p = model(a, b);
      end
      @(posedge clk);
   endtask

   // Walk the 4 CALC cycles, disturbing start/A/B, and check busy and done timing.
   task automatic follow(input bit hold);
      for (int e = 0; e < 4; e++) begin
         #1;
         check("busy_calc", 32'(busy), 32'd1);
         check("done_calc", 32'(done), 32'd0);
         @(negedge clk);
         A     = 4'($urandom);
         B     = 4'($urandom);
         start = hold ? 1'b1 : 1'($urandom);
         @(posedge clk);
      end
      #1;
      check("done_pulse", 32'(done), 32'd1);
      check("busy_done", 32'(busy), 32'd0);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      start = 1'b0;
      A     = 4'($urandom);
      B     = 4'($urandom);
      repeat (n) @(negedge clk);
      check("done_idle", 32'(done), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
      check("p_hold", 32'(P), 32'(last_p));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   logic [3:0] dir_a [7] = '{4'h3, 4'h7, 4'hA, 4'hF, 4'h0, 4'hF, 4'h1};
   logic [3:0] dir_b [7] = '{4'h3, 4'h1, 4'hA, 4'hF, 4'hF, 4'h0, 4'h8};

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      A      = 4'h0;
      B      = 4'h0;
      last_p = 8'h00;
      #1;
      check("rst_p", 32'(P), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Directed corner operands, each followed by idle cycles.
      for (int i = 0; i < 7; i++) begin
         launch(dir_a[i], dir_b[i], 1'b1);
         follow(1'b0);
         if (i == 0) check("p_3x3", 32'(P), 32'd9);
         idle(2);
      end

      // Reset at CALC cycle 2 aborts with no done pulse.
      launch(4'h7, 4'h5, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_p", 32'(P), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      last_p = 8'h00;
      @(negedge clk);
      start = 1'b1;
      A     = 4'h9;
      B     = 4'h9;
      repeat (3) @(negedge clk);
      check("rst_start_ignored", 32'(busy), 32'd0);
      start = 1'b0;
      rst   = 1'b0;
      idle(3);
      launch(4'h6, 4'h5, 1'b1);
      follow(1'b0);
      idle(1);

      // start held high: products back-to-back every 5 cycles.
      for (int i = 0; i < 4; i++) begin
         launch(4'($urandom), 4'($urandom), 1'b1);
         follow(1'b1);
      end
      idle(2);

      // Random mix of back-to-back and idle-separated operations.
      for (int i = 0; i < 40; i++) begin
         launch(4'($urandom), 4'($urandom), 1'b1);
         follow(1'b0);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      idle(3);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
